// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch and next-PC selection for the multi-cycle core.
// Fetches one word per instruction over a req/ack handshake, holds it for execute,
// and picks the next PC (sequential, branch, jump-immediate, jump-register) when
// the datapath signals exec_done.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata   instruction memory handshake
//   instr, opcode, function_val, instr_valid   latched instruction to decode/execute
//   exec_done, branch_type, counter_selector, reg_target, flag_*   next-PC inputs
//   pc, link_pc         current PC and pc+1 for jump-and-link
module fetch_sequencer #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        function_val,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic [3:0]        branch_type,
    input  logic [1:0]        counter_selector,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              flag_zero,
    input  logic              flag_carry,
    input  logic              flag_sign,
    input  logic              flag_overflow,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_pc
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;
    logic              taken;

    // Branch condition decode against the ALU flags
    always_comb begin
        taken = 1'b0;
        case (branch_type)
            4'b0000: taken = 1'b1;
            4'b0001: taken = flag_zero;
            4'b0010: taken = ~flag_zero;
            4'b0011: taken = flag_carry;
            4'b0100: taken = ~flag_carry;
            4'b0101: taken = flag_sign;
            4'b0110: taken = ~flag_sign;
            4'b0111: taken = flag_overflow;
            4'b1000: taken = ~flag_overflow;
            default: taken = 1'b0;
        endcase
    end

    assign pc_inc = pc_q + ADDR_W'(1);

    // Next-PC select; jumps outrank branches, selector 11 behaves as 00
    always_comb begin
        next_pc = pc_inc;
        case (counter_selector)
            2'b01:   next_pc = instr_q[ADDR_W-1:0];
            2'b10:   next_pc = reg_target;
            default: begin
                if (taken) begin
                    next_pc = pc_inc + ADDR_W'({{16{instr_q[15]}}, instr_q[15:0]});
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= PC_RST;
            link_q  <= PC_RST + ADDR_W'(1);
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
        end
    end

    // Next-state logic; exec_done re-raises the request directly so an
    // instruction can complete in two cycles
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        link_d  = link_q;
        case (state_q)
            FETCH: begin
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = EXEC;
                end else begin
                    req_d = 1'b1;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    pc_d    = next_pc;
                    link_d  = next_pc + ADDR_W'(1);
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
        endcase
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[31:26];
    assign function_val = instr_q[5:0];
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign link_pc      = link_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer (ADDR_W=16, RESET_PC=0).
module tb_fetch_sequencer;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic [5:0]    opcode;
    logic [5:0]    function_val;
    logic          instr_valid;
    logic          exec_done;
    logic [3:0]    branch_type;
    logic [1:0]    counter_selector;
    logic [AW-1:0] reg_target;
    logic          flag_zero, flag_carry, flag_sign, flag_overflow;
    logic [AW-1:0] pc;
    logic [AW-1:0] link_pc;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] cur_pc;

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .opcode           (opcode),
        .function_val     (function_val),
        .instr_valid      (instr_valid),
        .exec_done        (exec_done),
        .branch_type      (branch_type),
        .counter_selector (counter_selector),
        .reg_target       (reg_target),
        .flag_zero        (flag_zero),
        .flag_carry       (flag_carry),
        .flag_sign        (flag_sign),
        .flag_overflow    (flag_overflow),
        .pc               (pc),
        .link_pc          (link_pc)
    );

    always #5 clk = ~clk;

    // Record one check result
    task automatic chk(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One instruction: ack in the request cycle, exec_done the following cycle.
    // Entered and left at a falling edge with imem_req high.
    task automatic run_instr(input logic [31:0] word, input logic [3:0] bt,
                             input logic [1:0] cs, input logic [AW-1:0] rt,
                             input logic [3:0] zcsv, input logic [AW-1:0] exp_pc,
                             input string tag);
        chk({tag, " addr"}, imem_addr === cur_pc, 32'(imem_addr), 32'(cur_pc));
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        chk({tag, " valid"}, instr_valid === 1'b1, 32'(instr_valid), 32'd1);
        chk({tag, " link"}, link_pc === AW'(cur_pc + AW'(1)), 32'(link_pc), 32'(AW'(cur_pc + AW'(1))));
        branch_type      = bt;
        counter_selector = cs;
        reg_target       = rt;
        {flag_zero, flag_carry, flag_sign, flag_overflow} = zcsv;
        exec_done        = 1'b1;
        @(negedge clk);
        exec_done        = 1'b0;
        branch_type      = 4'b1001;
        counter_selector = 2'b00;
        reg_target       = '0;
        {flag_zero, flag_carry, flag_sign, flag_overflow} = 4'b0000;
        chk({tag, " pc"}, pc === exp_pc, 32'(pc), 32'(exp_pc));
        chk({tag, " req"}, imem_req === 1'b1, 32'(imem_req), 32'd1);
        cur_pc = exp_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        branch_type = 4'b1001; counter_selector = 2'b00; reg_target = '0;
        {flag_zero, flag_carry, flag_sign, flag_overflow} = 4'b0000;
        cur_pc = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst pc", pc === 16'h0000, 32'(pc), 32'h0);
        chk("rst req", imem_req === 1'b0, 32'(imem_req), 32'h0);
        chk("rst valid", instr_valid === 1'b0, 32'(instr_valid), 32'h0);
        chk("rst instr", instr === 32'h0, instr, 32'h0);
        chk("rst link", link_pc === 16'h0001, 32'(link_pc), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("first req", imem_req === 1'b1, 32'(imem_req), 32'h1);
        chk("first valid", instr_valid === 1'b0, 32'(instr_valid), 32'h0);

        // Basic 2-cycle instruction
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t1 instr", instr === 32'h0000_0020, instr, 32'h20);
        chk("t1 func", function_val === 6'h20, 32'(function_val), 32'h20);
        chk("t1 opcode", opcode === 6'h00, 32'(opcode), 32'h0);
        chk("t1 valid", instr_valid === 1'b1, 32'(instr_valid), 32'h1);
        chk("t1 req drop", imem_req === 1'b0, 32'(imem_req), 32'h0);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("t1 pc", pc === 16'h0001, 32'(pc), 32'h1);
        chk("t1 req", imem_req === 1'b1, 32'(imem_req), 32'h1);
        chk("t1 valid off", instr_valid === 1'b0, 32'(instr_valid), 32'h0);
        chk("t1 addr", imem_addr === 16'h0001, 32'(imem_addr), 32'h1);
        cur_pc = 16'h0001;

        // Conditional branches
        run_instr(32'h0, 4'b1001, 2'b10, 16'h0005, 4'b0000, 16'h0005, "jr5a");
        run_instr(32'h0000_FFFE, 4'b0001, 2'b00, '0, 4'b1000, 16'h0004, "bz taken");
        run_instr(32'h0, 4'b1001, 2'b10, 16'h0005, 4'b0000, 16'h0005, "jr5b");
        run_instr(32'h0000_FFFE, 4'b0001, 2'b00, '0, 4'b0000, 16'h0006, "bz not");
        run_instr(32'h0, 4'b1001, 2'b10, 16'h0005, 4'b0000, 16'h0005, "jr5c");
        run_instr(32'h0000_FFFE, 4'b1010, 2'b00, '0, 4'b1111, 16'h0006, "bt1010 never");
        run_instr(32'h0000_0003, 4'b0011, 2'b00, '0, 4'b0100, 16'h000A, "bc taken");
        run_instr(32'h0000_0003, 4'b0110, 2'b00, '0, 4'b0010, 16'h000B, "bns not");
        run_instr(32'h0000_FFF0, 4'b0111, 2'b11, '0, 4'b0001, 16'hFFFC, "bv cs11");

        // Jumps outrank an always-taken branch
        run_instr(32'h0400_0040, 4'b0000, 2'b01, '0, 4'b0000, 16'h0040, "jimm");
        run_instr(32'h0000_0040, 4'b0000, 2'b10, 16'h1234, 4'b0000, 16'h1234, "jreg");

        // PC wrap at the top of the address space
        run_instr(32'h0, 4'b1001, 2'b10, 16'hFFFF, 4'b0000, 16'hFFFF, "jmax");
        run_instr(32'h0, 4'b1001, 2'b00, '0, 4'b0000, 16'h0000, "wrap");

        // Delayed ack with a spurious exec_done during fetch
        exec_done = 1'b1; counter_selector = 2'b10; reg_target = 16'h0777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall req", imem_req === 1'b1, 32'(imem_req), 32'h1);
            chk("stall addr", imem_addr === 16'h0000, 32'(imem_addr), 32'h0);
            chk("stall valid", instr_valid === 1'b0, 32'(instr_valid), 32'h0);
        end
        exec_done = 1'b0; counter_selector = 2'b00; reg_target = '0;
        run_instr(32'h0, 4'b1001, 2'b00, '0, 4'b0000, 16'h0001, "after stall");

        // Reset mid-execute
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t6 in exec", instr_valid === 1'b1, 32'(instr_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6 exec rst pc", pc === 16'h0000, 32'(pc), 32'h0);
        chk("t6 exec rst valid", instr_valid === 1'b0, 32'(instr_valid), 32'h0);
        chk("t6 exec rst req", imem_req === 1'b0, 32'(imem_req), 32'h0);
        chk("t6 exec rst instr", instr === 32'h0, instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("t6 ack w/o req", instr_valid === 1'b0, 32'(instr_valid), 32'h0);
        chk("t6 refetch req", imem_req === 1'b1, 32'(imem_req), 32'h1);
        chk("t6 refetch addr", imem_addr === 16'h0000, 32'(imem_addr), 32'h0);

        // Reset mid-fetch
        rst = 1'b1;
        #1;
        chk("t6 fetch rst req", imem_req === 1'b0, 32'(imem_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6 req again", imem_req === 1'b1, 32'(imem_req), 32'h1);
        cur_pc = 16'h0000;
        run_instr(32'h0, 4'b1001, 2'b00, '0, 4'b0000, 16'h0001, "refetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
